// File: rtl/core_sched_pkg.sv
// Shared types and helpers for the in-order issue scoreboard.
//   sched_state_e : issue controller state (RUN / DRAIN)
//   NREG, REG_W   : registers per file and register-number width
//   onehot5to32() : decode a register number into a 32-bit mask
package core_sched_pkg;

  localparam int NREG  = 32;
  localparam int REG_W = 5;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sched_state_e;

  function automatic logic [NREG-1:0] onehot5to32(input logic [REG_W-1:0] num);
    logic [NREG-1:0] m;
    m = '0;
    m[num] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/core_busy_file.sv
// Pending-write bit vector for one register file.
//   clk_i, rst_i          : clock, async active-high reset
//   set_i, set_num_i      : mark a register busy (new writer issued)
//   clr_i, clr_num_i      : release a register (writeback)
//   busy_o                : registered pending-write vector
// X0_HOLD=1 pins bit 0 at zero (hardwired-zero register).
// A set and clear of the same bit in one cycle leaves the bit set, since
// the set belongs to a newer writer than the retiring one.
module core_busy_file
  import core_sched_pkg::*;
#(
  parameter bit X0_HOLD = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [REG_W-1:0] set_num_i,
  input  logic             clr_i,
  input  logic [REG_W-1:0] clr_num_i,
  output logic [NREG-1:0]  busy_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_m, clr_m;

  always_comb begin
    set_m  = set_i ? onehot5to32(set_num_i) : '0;
    clr_m  = clr_i ? onehot5to32(clr_num_i) : '0;
    busy_d = (busy_q & ~clr_m) | set_m;
    if (X0_HOLD) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/core_scoreboard.sv
// In-order issue controller between decode and execute.
// Tracks pending writes per integer/FP register, stalls on RAW/WAW hazards,
// execute backpressure and serializing instructions (which wait in DRAIN
// until nothing is in flight). Writebacks are bypassed into the same-cycle
// hazard check. STALL_CNT is a saturating count of stalled cycles.
// Ports:
//   CLK, RST                         : clock, async active-high reset
//   IN_VALID / IN_READY / ISSUE      : decode handshake (ready/issue comb.)
//   RS1/RS2/RD_*, FRS1/FRS2/FRD_*    : operand numbers and use/write flags
//   SERIAL                           : issue only with no writes in flight
//   EX_READY                         : execute stage can accept
//   WB_WE/WB_NUM, FWB_WE/FWB_NUM     : writeback retirement
//   FLUSH                            : blocks issue, returns to RUN
//   BUSY_INT, BUSY_FP, DRAINING      : registered status
//   STALL_CNT                        : saturating stall-cycle counter
module core_scoreboard
  import core_sched_pkg::*;
#(
  parameter int NREG_P = 32,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [REG_W-1:0]  RS1_NUM,
  input  logic [REG_W-1:0]  RS2_NUM,
  input  logic [REG_W-1:0]  RD_NUM,
  input  logic              RS1_USE,
  input  logic              RS2_USE,
  input  logic              RD_WE,
  input  logic [REG_W-1:0]  FRS1_NUM,
  input  logic [REG_W-1:0]  FRS2_NUM,
  input  logic [REG_W-1:0]  FRD_NUM,
  input  logic              FRS1_USE,
  input  logic              FRS2_USE,
  input  logic              FRD_WE,
  input  logic              SERIAL,
  input  logic              EX_READY,
  output logic              ISSUE,
  input  logic              WB_WE,
  input  logic [REG_W-1:0]  WB_NUM,
  input  logic              FWB_WE,
  input  logic [REG_W-1:0]  FWB_NUM,
  input  logic              FLUSH,
  output logic [NREG_P-1:0] BUSY_INT,
  output logic [NREG_P-1:0] BUSY_FP,
  output logic              DRAINING,
  output logic [CNT_W-1:0]  STALL_CNT
);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]  busy_int, busy_fp, eff_int, eff_fp;
  logic             hazard, all_clear, stall;

  core_busy_file #(.X0_HOLD(1'b1)) u_busy_int (
    .clk_i(CLK), .rst_i(RST),
    .set_i(ISSUE & RD_WE), .set_num_i(RD_NUM),
    .clr_i(WB_WE), .clr_num_i(WB_NUM),
    .busy_o(busy_int)
  );

  core_busy_file #(.X0_HOLD(1'b0)) u_busy_fp (
    .clk_i(CLK), .rst_i(RST),
    .set_i(ISSUE & FRD_WE), .set_num_i(FRD_NUM),
    .clr_i(FWB_WE), .clr_num_i(FWB_NUM),
    .busy_o(busy_fp)
  );

  // Retiring register is treated as free in the same cycle.
  assign eff_int = busy_int & ~(WB_WE  ? onehot5to32(WB_NUM)  : '0);
  assign eff_fp  = busy_fp  & ~(FWB_WE ? onehot5to32(FWB_NUM) : '0);

  // RD/FRD terms are the WAW checks.
  assign hazard = (RS1_USE  & eff_int[RS1_NUM])  | (RS2_USE  & eff_int[RS2_NUM])
                | (RD_WE    & eff_int[RD_NUM])
                | (FRS1_USE & eff_fp[FRS1_NUM])  | (FRS2_USE & eff_fp[FRS2_NUM])
                | (FRD_WE   & eff_fp[FRD_NUM]);

  assign all_clear = ~|eff_int & ~|eff_fp;

  always_comb begin
    state_d  = state_q;
    IN_READY = 1'b0;
    unique case (state_q)
      RUN: begin
        IN_READY = EX_READY & ~hazard & ~FLUSH & (~SERIAL | all_clear);
        if (IN_VALID & SERIAL & ~all_clear & ~FLUSH) state_d = DRAIN;
      end
      DRAIN: begin
        IN_READY = EX_READY & all_clear & ~FLUSH;
        if ((IN_VALID & IN_READY) | FLUSH) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign ISSUE = IN_VALID & IN_READY;
  assign stall = IN_VALID & ~IN_READY & ~FLUSH;
  assign cnt_d = (stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY_INT  = busy_int;
  assign BUSY_FP   = busy_fp;
  assign DRAINING  = (state_q == DRAIN);
  assign STALL_CNT = cnt_q;

endmodule

// File: tb/tb_core_scoreboard.sv
// Directed bench for core_scoreboard: hazards, x0/f0, serialize/drain,
// set-over-clear, flush, async reset and counter saturation (CNT_W=4 copy).
module tb_core_scoreboard;

  logic       CLK = 1'b0, RST;
  logic       IN_VALID, SERIAL, EX_READY, FLUSH;
  logic [4:0] RS1_NUM, RS2_NUM, RD_NUM, FRS1_NUM, FRS2_NUM, FRD_NUM;
  logic       RS1_USE, RS2_USE, RD_WE, FRS1_USE, FRS2_USE, FRD_WE;
  logic       WB_WE, FWB_WE;
  logic [4:0] WB_NUM, FWB_NUM;

  logic        IN_READY, ISSUE, DRAINING, IN_READY4, ISSUE4, DRAINING4;
  logic [31:0] BUSY_INT, BUSY_FP, STALL_CNT, BUSY_INT4, BUSY_FP4;
  logic [3:0]  STALL_CNT4;

  int n_chk = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  core_scoreboard #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .RS1_NUM(RS1_NUM), .RS2_NUM(RS2_NUM), .RD_NUM(RD_NUM),
    .RS1_USE(RS1_USE), .RS2_USE(RS2_USE), .RD_WE(RD_WE),
    .FRS1_NUM(FRS1_NUM), .FRS2_NUM(FRS2_NUM), .FRD_NUM(FRD_NUM),
    .FRS1_USE(FRS1_USE), .FRS2_USE(FRS2_USE), .FRD_WE(FRD_WE),
    .SERIAL(SERIAL), .EX_READY(EX_READY), .ISSUE(ISSUE),
    .WB_WE(WB_WE), .WB_NUM(WB_NUM), .FWB_WE(FWB_WE), .FWB_NUM(FWB_NUM),
    .FLUSH(FLUSH), .BUSY_INT(BUSY_INT), .BUSY_FP(BUSY_FP),
    .DRAINING(DRAINING), .STALL_CNT(STALL_CNT)
  );

  core_scoreboard #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY4),
    .RS1_NUM(RS1_NUM), .RS2_NUM(RS2_NUM), .RD_NUM(RD_NUM),
    .RS1_USE(RS1_USE), .RS2_USE(RS2_USE), .RD_WE(RD_WE),
    .FRS1_NUM(FRS1_NUM), .FRS2_NUM(FRS2_NUM), .FRD_NUM(FRD_NUM),
    .FRS1_USE(FRS1_USE), .FRS2_USE(FRS2_USE), .FRD_WE(FRD_WE),
    .SERIAL(SERIAL), .EX_READY(EX_READY), .ISSUE(ISSUE4),
    .WB_WE(WB_WE), .WB_NUM(WB_NUM), .FWB_WE(FWB_WE), .FWB_NUM(FWB_NUM),
    .FLUSH(FLUSH), .BUSY_INT(BUSY_INT4), .BUSY_FP(BUSY_FP4),
    .DRAINING(DRAINING4), .STALL_CNT(STALL_CNT4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Zero all per-cycle instruction and writeback inputs (EX_READY kept high).
  task automatic idle();
    IN_VALID = 0; SERIAL = 0; FLUSH = 0; EX_READY = 1;
    RS1_NUM = 0; RS2_NUM = 0; RD_NUM = 0; RS1_USE = 0; RS2_USE = 0; RD_WE = 0;
    FRS1_NUM = 0; FRS2_NUM = 0; FRD_NUM = 0; FRS1_USE = 0; FRS2_USE = 0; FRD_WE = 0;
    WB_WE = 0; WB_NUM = 0; FWB_WE = 0; FWB_NUM = 0;
  endtask

  // Commit on posedge, return at the following negedge for sampling.
  task automatic tick();
    @(posedge CLK); @(negedge CLK);
  endtask

  initial begin
    idle(); EX_READY = 0; RST = 1;
    #2;
    chk("rst_busy_int", BUSY_INT, 0);
    chk("rst_busy_fp",  BUSY_FP, 0);
    chk("rst_draining", DRAINING, 0);
    chk("rst_cnt",      STALL_CNT, 0);
    chk("rst_ready",    IN_READY, 0);
    @(negedge CLK); RST = 0; idle();

    // RAW stall on x5
    IN_VALID = 1; RD_WE = 1; RD_NUM = 5; #1;
    chk("raw_issue_add", ISSUE, 1);
    tick();
    chk("raw_busy_set", BUSY_INT, 32'h20);
    idle(); IN_VALID = 1; RS1_USE = 1; RS1_NUM = 5; #1;
    chk("raw_stall_ready", IN_READY, 0);
    tick(); tick(); tick();
    chk("raw_stall_cnt", STALL_CNT, 3);
    WB_WE = 1; WB_NUM = 5; RD_WE = 1; RD_NUM = 5; #1;
    chk("raw_wb_bypass", IN_READY, 1);
    tick();
    chk("raw_rewrite_busy", BUSY_INT, 32'h20);
    chk("raw_cnt_hold", STALL_CNT, 3);
    idle(); WB_WE = 1; WB_NUM = 5;
    tick();
    chk("raw_wb_clear", BUSY_INT, 0);

    // x0 never busy, f0 ordinary
    idle(); IN_VALID = 1; RD_WE = 1; RD_NUM = 0; FRD_WE = 1; FRD_NUM = 0;
    tick();
    chk("x0_not_busy", BUSY_INT, 0);
    chk("f0_busy", BUSY_FP, 32'h1);
    idle(); IN_VALID = 1; FRS2_USE = 1; FRS2_NUM = 0; #1;
    chk("f0_stall", IN_READY, 0);
    FWB_WE = 1; FWB_NUM = 0; EX_READY = 0; #1;
    chk("exready_block", IN_READY, 0);
    EX_READY = 1; #1;
    chk("f0_wb_bypass", ISSUE, 1);
    tick();
    chk("f0_cleared", BUSY_FP, 0);
    chk("f0_cnt", STALL_CNT, 3);

    // Serialize with f3 in flight
    idle(); IN_VALID = 1; FRD_WE = 1; FRD_NUM = 3;
    tick();
    chk("ser_busy_fp", BUSY_FP, 32'h8);
    idle(); IN_VALID = 1; SERIAL = 1; #1;
    chk("ser_run_ready", IN_READY, 0);
    tick();
    chk("ser_draining", DRAINING, 1);
    chk("ser_drain_ready", IN_READY, 0);
    chk("ser_cnt", STALL_CNT, 4);
    FWB_WE = 1; FWB_NUM = 3; #1;
    chk("ser_issue", ISSUE, 1);
    tick();
    chk("ser_back_run", DRAINING, 0);
    chk("ser_fp_clear", BUSY_FP, 0);

    // Set-over-clear on x7 (also exercises WAW bypass)
    idle(); IN_VALID = 1; RD_WE = 1; RD_NUM = 7;
    tick();
    chk("soc_first", BUSY_INT, 32'h80);
    WB_WE = 1; WB_NUM = 7; #1;
    chk("soc_waw_bypass", ISSUE, 1);
    tick();
    chk("soc_set_wins", BUSY_INT, 32'h80);

    // FLUSH in DRAIN
    idle(); IN_VALID = 1; SERIAL = 1;
    tick();
    chk("fl_draining", DRAINING, 1);
    chk("fl_cnt_pre", STALL_CNT, 5);
    FLUSH = 1; #1;
    chk("fl_ready", IN_READY, 0);
    chk("fl_issue", ISSUE, 0);
    tick();
    chk("fl_run", DRAINING, 0);
    chk("fl_busy_kept", BUSY_INT, 32'h80);
    chk("fl_cnt_hold", STALL_CNT, 5);

    // Async reset mid-drain
    FLUSH = 0;
    tick();
    chk("ar_draining", DRAINING, 1);
    #2 RST = 1; #1;
    chk("ar_busy", BUSY_INT, 0);
    chk("ar_drain", DRAINING, 0);
    chk("ar_cnt", STALL_CNT, 0);
    @(negedge CLK); RST = 0; idle();

    // Saturation: 20 stalled cycles
    IN_VALID = 1; RD_WE = 1; RD_NUM = 9;
    tick();
    chk("sat_busy", BUSY_INT, 32'h200);
    idle(); IN_VALID = 1; RS2_USE = 1; RS2_NUM = 9;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt32", STALL_CNT, 20);
    chk("sat_cnt4", STALL_CNT4, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
